// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWaitWr,
        StResp
    } state_e;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned WR_TIMEOUT_DEF = 4;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner selection between the fetch and data requesters.
// On a tie the port that was not served last wins; a constant pointer gives fixed priority.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req[PORT_F] && req[PORT_D]) begin
            gnt = (last == PORT_F) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port memory arbiter: fetch (f) and data (d) requesters share one memory port.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is data-port priority.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned WR_TIMEOUT = WR_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_f,
    input  logic        req_d,
    input  logic [15:0] addr_f,
    input  logic [15:0] addr_d,
    input  logic        wr_f,
    input  logic        wr_d,
    input  logic [15:0] wdata_f,
    input  logic [15:0] wdata_d,
    output logic        gnt_f,
    output logic        gnt_d,
    output logic        done_f,
    output logic        done_d,
    output logic [15:0] rdata_f,
    output logic [15:0] rdata_d,
    output logic        err_f,
    output logic        err_d,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_err,
    input  logic        mem_wr_success
);

    localparam int unsigned CntW = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WR_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            lat_wr_q, lat_wr_d;
    logic [15:0]     lat_addr_q, lat_addr_d;
    logic [15:0]     lat_wdata_q, lat_wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     res_f_data_q, res_f_data_d, res_d_data_q, res_d_data_d;
    logic            res_f_err_q, res_f_err_d, res_d_err_q, res_d_err_d;

    logic            ptr;
    logic [1:0]      sel;
    logic            idle;
    logic            res_load;
    logic [15:0]     res_data;
    logic            res_err;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;
    assign ptr = last_q;
`else
    assign ptr = PORT_F;
`endif

    mem_arb_sel u_sel (
        .req  ({req_d, req_f}),
        .last (ptr),
        .gnt  (sel)
    );

    assign idle  = (state_q == StIdle);
    // Gate with rst so no grant can escape while reset is held.
    assign gnt_f = rst & idle & sel[PORT_F];
    assign gnt_d = rst & idle & sel[PORT_D];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_wr_d    = lat_wr_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        cnt_d       = cnt_q;
        res_load    = 1'b0;
        res_data    = '0;
        res_err     = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|sel) begin
                    owner_d     = sel[PORT_D] ? PORT_D : PORT_F;
                    lat_wr_d    = sel[PORT_D] ? wr_d : wr_f;
                    lat_addr_d  = sel[PORT_D] ? addr_d : addr_f;
                    lat_wdata_d = sel[PORT_D] ? wdata_d : wdata_f;
`ifdef MEM_ARB_RR_EN
                    last_d      = sel[PORT_D] ? PORT_D : PORT_F;
`endif
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (!lat_wr_q || mem_err) begin
                    res_load = 1'b1;
                    res_data = lat_wr_q ? 16'h0000 : mem_rdata;
                    res_err  = mem_err;
                    state_d  = StResp;
                end else begin
                    cnt_d   = '0;
                    state_d = StWaitWr;
                end
            end
            StWaitWr: begin
                if (mem_wr_success) begin
                    res_load = 1'b1;
                    state_d  = StResp;
                end else if (cnt_q == CntLast) begin
                    res_load = 1'b1;
                    res_err  = 1'b1;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        res_f_data_d = res_f_data_q;
        res_f_err_d  = res_f_err_q;
        res_d_data_d = res_d_data_q;
        res_d_err_d  = res_d_err_q;
        if (res_load) begin
            if (owner_q == PORT_D) begin
                res_d_data_d = res_data;
                res_d_err_d  = res_err;
            end else begin
                res_f_data_d = res_data;
                res_f_err_d  = res_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            owner_q      <= PORT_F;
            lat_wr_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            cnt_q        <= '0;
            res_f_data_q <= '0;
            res_f_err_q  <= 1'b0;
            res_d_data_q <= '0;
            res_d_err_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q       <= PORT_F;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_wr_q     <= lat_wr_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            cnt_q        <= cnt_d;
            res_f_data_q <= res_f_data_d;
            res_f_err_q  <= res_f_err_d;
            res_d_data_q <= res_d_data_d;
            res_d_err_q  <= res_d_err_d;
`ifdef MEM_ARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

    assign done_f    = (state_q == StResp) && (owner_q == PORT_F);
    assign done_d    = (state_q == StResp) && (owner_q == PORT_D);
    assign rdata_f   = res_f_data_q;
    assign rdata_d   = res_d_data_q;
    assign err_f     = res_f_err_q;
    assign err_d     = res_d_err_q;

    assign mem_en    = (state_q == StAccess);
    assign mem_wr    = mem_en & lat_wr_q;
    assign mem_addr  = mem_en ? lat_addr_q : 16'h0000;
    assign mem_wdata = mem_en ? lat_wdata_q : 16'h0000;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed vector table, hand sequences and a randomized
// run checked against a transaction-level reference model (shadow memory + served-last port).
module tb_mem_arb;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_f, req_d, wr_f, wr_d;
    logic [15:0] addr_f, addr_d, wdata_f, wdata_d;
    logic        gnt_f, gnt_d, done_f, done_d, err_f, err_d;
    logic [15:0] rdata_f, rdata_d;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, mem_err;
    logic        mem_wr_success;
    logic        succ_en;

    logic [15:0] mem    [256];
    logic [15:0] shadow [256];
    logic        m_last;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic        rf, rd, wr_fv, wr_dv;
        logic [15:0] af, ad, df, dd;
        logic        succ, ep;
        int unsigned elat;
        logic [15:0] erd;
        logic        eerr;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    mem_arb #(.WR_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_f          (req_f),
        .req_d          (req_d),
        .addr_f         (addr_f),
        .addr_d         (addr_d),
        .wr_f           (wr_f),
        .wr_d           (wr_d),
        .wdata_f        (wdata_f),
        .wdata_d        (wdata_d),
        .gnt_f          (gnt_f),
        .gnt_d          (gnt_d),
        .done_f         (done_f),
        .done_d         (done_d),
        .rdata_f        (rdata_f),
        .rdata_d        (rdata_d),
        .err_f          (err_f),
        .err_d          (err_d),
        .mem_addr       (mem_addr),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err),
        .mem_wr_success (mem_wr_success)
    );

    // Memory device: word array, misaligned accesses fault, write ack one cycle later.
    assign mem_err   = mem_en & mem_addr[0];
    assign mem_rdata = mem[mem_addr[8:1]];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8] <= 16'hBEEF;
            mem_wr_success <= 1'b0;
        end else begin
            mem_wr_success <= 1'b0;
            if (mem_en && mem_wr && !mem_err) begin
                mem[mem_addr[8:1]] <= mem_wdata;
                mem_wr_success <= succ_en;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init();
        for (int i = 0; i < 256; i++) shadow[i] = 16'h0000;
        shadow[8] = 16'hBEEF;
        m_last = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".ctl"}, {gnt_f, gnt_d, done_f, done_d, err_f, err_d, mem_en, mem_wr}, 32'h0);
        chk({nm, ".rdata"}, {rdata_f, rdata_d}, 32'h0);
        chk({nm, ".membus"}, {mem_addr, mem_wdata}, 32'h0);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b0;
        #1;
        chk_zero(nm);
        tick();
        chk({nm, ".done_held"}, {done_f, done_d}, 32'h0);
        tick();
        rst = 1'b1;
        model_init();
        tick();
    endtask

    function automatic vec_t mk(input logic rf, input logic rd, input logic wfv, input logic wdv,
                                input logic [15:0] af, input logic [15:0] ad,
                                input logic [15:0] df, input logic [15:0] dd,
                                input logic succ, input logic ep, input int unsigned elat,
                                input logic [15:0] erd, input logic eerr);
        vec_t v;
        v.rf = rf; v.rd = rd; v.wr_fv = wfv; v.wr_dv = wdv;
        v.af = af; v.ad = ad; v.df = df; v.dd = dd;
        v.succ = succ; v.ep = ep; v.elat = elat; v.erd = erd; v.eerr = eerr;
        return v;
    endfunction

    // One transaction from an idle arbiter; checks grant, memory cycle, latency and response.
    task automatic run_txn(input string nm, input vec_t v);
        logic        ww;
        logic [15:0] wa, wd;
        int          lat;
        logic        got;
        ww = v.ep ? v.wr_dv : v.wr_fv;
        wa = v.ep ? v.ad : v.af;
        wd = v.ep ? v.dd : v.df;
        req_f = v.rf; req_d = v.rd; wr_f = v.wr_fv; wr_d = v.wr_dv;
        addr_f = v.af; addr_d = v.ad; wdata_f = v.df; wdata_d = v.dd;
        succ_en = v.succ;
        #1;
        chk({nm, ".gnt"}, {gnt_d, gnt_f}, v.ep ? 32'h2 : 32'h1);
        chk({nm, ".idle_mem_en"}, mem_en, 32'h0);
        tick();
        req_f = 1'b0; req_d = 1'b0;
        #1;
        chk({nm, ".access_en"}, {mem_en, mem_wr}, {30'h0, 1'b1, ww});
        chk({nm, ".access_addr"}, mem_addr, wa);
        if (ww) chk({nm, ".access_wdata"}, mem_wdata, wd);
        lat = 1;
        got = 1'b0;
        while (!got && lat < int'(v.elat) + 6) begin
            tick();
            lat++;
            if (lat == 2) chk({nm, ".post_access_bus"}, {mem_en, mem_addr}, 32'h0);
            if (done_f || done_d) got = 1'b1;
        end
        chk({nm, ".done_seen"}, got, 32'h1);
        chk({nm, ".latency"}, lat, v.elat);
        chk({nm, ".done_port"}, {done_d, done_f}, v.ep ? 32'h2 : 32'h1);
        chk({nm, ".rdata"}, v.ep ? rdata_d : rdata_f, v.erd);
        chk({nm, ".err"}, v.ep ? err_d : err_f, v.eerr);
        tick();
        chk({nm, ".done_pulse"}, {done_d, done_f}, 32'h0);
        if (ww && !wa[0]) shadow[wa[8:1]] = wd;
        m_last = v.ep;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        v;
        logic [3:0]  eord;
        int          ng, ndone;
        req_f = 1'b1; req_d = 1'b1; wr_f = 1'b0; wr_d = 1'b0;
        addr_f = 16'h0; addr_d = 16'h0; wdata_f = 16'h0; wdata_d = 16'h0;
        succ_en = 1'b1;

        // Reset with both requests asserted: nothing may leak out.
        #2;
        chk_zero("reset");
        tick();
        tick();
        req_f = 1'b0; req_d = 1'b0;
        rst = 1'b1;
        model_init();
        tick();

        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 2, 16'hBEEF, 1'b0);
        tbl[1] = mk(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'h0000, 16'h1234,
                    1'b1, 1'b1, 3, 16'h0000, 1'b0);
        tbl[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0020, 16'h0000, 16'h0000,
                    1'b1, 1'b1, 2, 16'h1234, 1'b0);
        tbl[3] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0021, 16'h0000, 16'h0000,
                    1'b1, 1'b1, 2, 16'h1234, 1'b1);
        tbl[4] = mk(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0021, 16'h0000, 16'h5678,
                    1'b1, 1'b1, 2, 16'h0000, 1'b1);
        tbl[5] = mk(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0030, 16'h0000, 16'hABCD,
                    1'b0, 1'b1, 2 + TO, 16'h0000, 1'b1);
        tbl[6] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 2, 16'h1234, 1'b0);
        tbl[7] = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5555, 16'h0000,
                    1'b1, 1'b0, 3, 16'h0000, 1'b0);
        tbl[8] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0040, 16'h0000, 16'h0000,
                    1'b1, 1'b1, 2, 16'h5555, 1'b0);
`ifdef MEM_ARB_RR_EN
        tbl[9] = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0030, 16'h0000, 16'h0000,
                    1'b1, 1'b0, 2, 16'hBEEF, 1'b0);
`else
        tbl[9] = mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0030, 16'h0000, 16'h0000,
                    1'b1, 1'b1, 2, 16'hABCD, 1'b0);
`endif
        for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        // Contention: both requests held across four transactions, served back to back.
        do_reset("rst_contend");
`ifdef MEM_ARB_RR_EN
        eord = 4'b0101;
`else
        eord = 4'b1111;
`endif
        req_f = 1'b1; req_d = 1'b1; wr_f = 1'b0; wr_d = 1'b0;
        addr_f = 16'h0010; addr_d = 16'h0020;
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            #1;
            if (gnt_f || gnt_d) begin
                chk($sformatf("contend%0d.gnt", ng), {gnt_d, gnt_f}, eord[ng] ? 32'h2 : 32'h1);
                chk($sformatf("contend%0d.cycle", ng), c, 3 * ng);
                ng++;
            end
            tick();
        end
        req_f = 1'b0; req_d = 1'b0;
        chk("contend.count", ng, 4);
        m_last = eord[3];
        tick(); tick(); tick();

        // Randomized transactions against the shadow-memory model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            logic        ww;
            logic [15:0] wa, wd;
            r = $urandom;
            v.rf = r[0] | ~r[1];
            v.rd = r[1];
            v.wr_fv = r[2]; v.wr_dv = r[3];
            v.af = {11'h008, r[7:4], (r[19:17] == 3'd0)};
            v.ad = {11'h008, r[11:8], (r[22:20] == 3'd0)};
            v.df = $urandom; v.dd = $urandom;
            v.succ = (r[13:12] != 2'd0);
`ifdef MEM_ARB_RR_EN
            v.ep = (v.rf && v.rd) ? ~m_last : v.rd;
`else
            v.ep = v.rd;
`endif
            ww = v.ep ? v.wr_dv : v.wr_fv;
            wa = v.ep ? v.ad : v.af;
            wd = v.ep ? v.dd : v.df;
            if (wa[0]) begin
                v.elat = 2; v.eerr = 1'b1; v.erd = ww ? 16'h0000 : shadow[wa[8:1]];
            end else if (ww) begin
                v.elat = v.succ ? 3 : 2 + TO; v.eerr = ~v.succ; v.erd = 16'h0000;
            end else begin
                v.elat = 2; v.eerr = 1'b0; v.erd = shadow[wa[8:1]];
            end
            run_txn($sformatf("rnd%0d", i), v);
        end

        // Reset while a write waits for its ack: abandoned without a done pulse.
        run_txn("pre_rst", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000,
                              1'b1, 1'b0, 2, 16'hBEEF, 1'b0));
        req_d = 1'b1; wr_d = 1'b1; addr_d = 16'h0022; wdata_d = 16'h7777; succ_en = 1'b0;
        #1;
        chk("wait_rst.gnt", {gnt_d, gnt_f}, 32'h2);
        tick();
        req_d = 1'b0;
        tick();
        tick();
        do_reset("wait_rst");
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (done_f || done_d) ndone++;
            tick();
        end
        chk("wait_rst.no_done", ndone, 0);
        run_txn("post_rst", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000,
                               1'b1, 1'b0, 2, 16'hBEEF, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter WR_TIMEOUT, default 4, cycles to wait for mem_wr_success before flagging error.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req_f / req_d  input  1  fetch / data requester request.
REQ-005 SHALL have ports addr_f / addr_d  input  16  byte address.
REQ-006 SHALL have ports wr_f / wr_d  input  1  write (1) or read (0).
REQ-007 SHALL have ports wdata_f / wdata_d  input  16  write data.
REQ-008 SHALL have ports gnt_f / gnt_d  output  1  one-cycle accept pulse; inputs captured that cycle.
REQ-009 SHALL have ports done_f / done_d  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports rdata_f / rdata_d  output  16  read data, valid with done.
REQ-011 SHALL have ports err_f / err_d  output  1  access error, valid with done.
REQ-012 SHALL have memory-side ports mem_addr  output  16, mem_en  output  1, mem_wr  output  1, mem_wdata  output  16.
REQ-013 SHALL have memory-side ports mem_rdata  input  16 (combinational read), mem_err  input  1, mem_wr_success  input  1 (registered, one cycle after write).

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, WAIT_WR, RESP.
REQ-015 IDLE: if any req, SHALL select one winner, pulse its gnt, latch its addr/wr/wdata and owner, go ACCESS; else stay.
REQ-016 ACCESS: SHALL drive mem_en=1, mem_addr/mem_wr/mem_wdata from latched values, for exactly one cycle.
REQ-017 ACCESS read, or mem_err=1: SHALL register mem_rdata and mem_err into owner's rdata/err, go RESP.
REQ-018 ACCESS write with mem_err=0: SHALL go WAIT_WR with mem_en=0.
REQ-019 WAIT_WR: mem_wr_success=1 -> err=0, go RESP; after WR_TIMEOUT cycles without it -> err=1, go RESP.
REQ-020 RESP: SHALL pulse owner's done one cycle, then go IDLE; rdata/err hold until owner's next done.
REQ-021 Latency: gnt at cycle N; done at N+2 for reads/errors, N+3 for successful writes.
REQ-022 mem_en, mem_wr SHALL be 0 outside ACCESS; mem_addr, mem_wdata SHALL be 0 outside ACCESS.
REQ-023 req sampled only in IDLE; req may drop after gnt; req asserted during RESP is served on the following IDLE cycle.
REQ-024 rdata SHALL be 0 on writes; err on misaligned address (addr[0]=1) comes from mem_err, never suppressed.
REQ-025 At most one gnt and one done SHALL be asserted per cycle; gnt_f and gnt_d never together.

Reset
REQ-026 rst low SHALL immediately force IDLE, all outputs 0, rdata/err 0, round-robin pointer to "fetch served last".
REQ-027 Reset mid-operation SHALL abandon the transaction with no done pulse.

Configuration
REQ-028 With MEM_ARB_RR_EN defined, simultaneous requests SHALL alternate: the port not served last wins; pointer updates on each gnt.
REQ-029 Without MEM_ARB_RR_EN, data port SHALL always win over fetch on simultaneous request; no pointer state exists.

Structure
REQ-030 Package mem_arb_pkg SHALL hold state enum, port index constants (PORT_F=0, PORT_D=1) and default WR_TIMEOUT.
REQ-031 Winner selection SHALL be in sub-module mem_arb_sel (requests + pointer in, one-hot grant out, combinational).

Verification
REQ-032 Read: req_f, addr_f=16'h0010, mem holds 16'hBEEF -> gnt_f N, mem_en N+1, done_f N+2, rdata_f=16'hBEEF, err_f=0.
REQ-033 Write: req_d, wr_d=1, addr_d=16'h0020, wdata_d=16'h1234 -> mem_wr N+1, done_d N+3, err_d=0, readback 16'h1234.
REQ-034 Misaligned: req_d read addr_d=16'h0021 -> done_d at N+2, err_d=1; write to 16'h0021 -> done_d N+2, err_d=1, no WAIT_WR.
REQ-035 Contention: req_f and req_d held 4 transactions -> RR order D,F,D,F; without macro D,D,D,D with fetch starved.
REQ-036 Timeout: mem_wr_success tied 0 on write -> done_d at N+2+WR_TIMEOUT, err_d=1.
REQ-037 Reset in WAIT_WR: rst low -> all outputs 0 same cycle, no done; post-reset read completes normally.
